// File: rtl/des_result_reader.sv
// des_result_reader: buffers 64-bit des results in a FIFO and
// returns them to a 32-bit reader as low word, then high word.
module des_result_reader #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [63:0]              i_ciphertext,
    input  logic                     i_dv,
    output logic [31:0]              o_rdata,
    output logic                     o_rvalid,
    input  logic                     i_rready,
    output logic                     o_word_hi,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow,
    input  logic                     i_clr_ovf,
    output logic [CNT_W-1:0]         o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);

    typedef enum logic {
        W_LO = 1'b0,
        W_HI = 1'b1
    } half_e;

    half_e              half_q, half_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [63:0]        mem_q [DEPTH];

    logic               rvalid;
    logic               xfer;
    logic               pop;
    logic               space;
    logic               push;
    logic [63:0]        head;

    // Handshake decode; a pop in this cycle frees a slot for a write.
    always_comb begin
        rvalid = (level_q != '0);
        xfer   = rvalid & i_rready;
        pop    = xfer & (half_q == W_HI);
        space  = (level_q != FULL) | pop;
        push   = i_dv & space;
    end

    // Word-half FSM: advances only on reader transfers.
    always_comb begin
        half_d = half_q;
        unique case (half_q)
            W_LO: if (xfer) half_d = W_HI;
            W_HI: if (xfer) half_d = W_LO;
            default: half_d = W_LO;
        endcase
    end

    // Pointer and occupancy bookkeeping.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Sticky loss flag and accepted-result counter; a drop beats clear.
    always_comb begin
        ovf_d   = ovf_q;
        count_d = count_q;
        if (i_dv && !space) begin
            ovf_d = 1'b1;
        end else if (i_clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (push) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            half_q   <= W_LO;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            half_q   <= half_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since level gates reads.
    always_ff @(posedge i_clk) begin
        if (!i_rst && push) begin
            mem_q[wr_ptr_q] <= i_ciphertext;
        end
    end

    // Read word select, forced to zero while empty.
    always_comb begin
        head    = mem_q[rd_ptr_q];
        o_rdata = 32'd0;
        if (rvalid) begin
            o_rdata = (half_q == W_HI) ? head[63:32] : head[31:0];
        end
    end

    assign o_rvalid   = rvalid;
    assign o_word_hi  = (half_q == W_HI);
    assign o_level    = level_q;
    assign o_overflow = ovf_q;
    assign o_count    = count_q;

endmodule

// File: tb/tb_des_result_reader.sv
// tb_des_result_reader: directed vectors, hand sequences and a
// queue model for the des result reader.
module tb_des_result_reader;

    logic        clk;
    logic        rst;
    logic [63:0] ct;
    logic        dv;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic        word_hi;
    logic [3:0]  level;
    logic        ovf;
    logic        clr;
    logic [15:0] count;

    int nchk;
    int nerr;

    des_result_reader #(.DEPTH(8), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_ciphertext(ct), .i_dv(dv),
        .o_rdata(rdata), .o_rvalid(rvalid), .i_rready(rready),
        .o_word_hi(word_hi), .o_level(level), .o_overflow(ovf),
        .i_clr_ovf(clr), .o_count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        dv;
        logic [63:0] data;
        logic        rr;
        logic        clr;
        logic        e_rv;
        logic [31:0] e_rd;
        logic        e_hi;
        logic [3:0]  e_lvl;
        logic        e_ovf;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vt [8];

    logic [63:0] mq [$];
    logic        mhi;
    logic        movf;
    logic [15:0] mcnt;

    task automatic chk(input string n, input logic [63:0] a,
                       input logic [63:0] e);
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    task automatic step(input logic r, input logic d,
                        input logic [63:0] x, input logic rr,
                        input logic c);
        rst = r; dv = d; ct = x; rready = rr; clr = c;
        @(posedge clk);
        #1;
        rst = 1'b0; dv = 1'b0; rready = 1'b0; clr = 1'b0;
    endtask

    task automatic mreset();
        mq.delete();
        mhi  = 1'b0;
        movf = 1'b0;
        mcnt = '0;
    endtask

    task automatic mstep(input logic d, input logic [63:0] x,
                         input logic rr, input logic c);
        logic [31:0] erd;
        logic        xf;
        logic        pp;
        logic        sp;
        erd = 32'd0;
        if (mq.size() != 0) begin
            erd = mhi ? mq[0][63:32] : mq[0][31:0];
        end
        chk("m_rvalid", 64'(rvalid), 64'(mq.size() != 0));
        chk("m_rdata", 64'(rdata), 64'(erd));
        chk("m_hi", 64'(word_hi), 64'(mhi));
        chk("m_level", 64'(level), 64'(mq.size()));
        chk("m_ovf", 64'(ovf), 64'(movf));
        chk("m_count", 64'(count), 64'(mcnt));
        step(1'b0, d, x, rr, c);
        xf = (mq.size() != 0) && rr;
        pp = xf && mhi;
        sp = (mq.size() < 8) || pp;
        if (pp) begin
            void'(mq.pop_front());
            mhi = 1'b0;
        end else if (xf) begin
            mhi = 1'b1;
        end
        if (d && sp) begin
            mq.push_back(x);
            mcnt = mcnt + 16'd1;
        end
        if (d && !sp) movf = 1'b1;
        else if (c) movf = 1'b0;
    endtask

    initial begin
        logic [63:0] nv;
        int ndv;
        nchk = 0;
        nerr = 0;
        rst = 1'b0; dv = 1'b0; ct = '0; rready = 1'b0; clr = 1'b0;

        vt[0] = '{1, 0, 64'h0, 0, 0, 0, 32'h0, 0, 4'd0, 0, 16'd0};
        vt[1] = '{0, 1, 64'h958313539316391d, 1, 0,
                  1, 32'h9316391d, 0, 4'd1, 0, 16'd1};
        vt[2] = '{0, 0, 64'h0, 1, 0, 1, 32'h95831353, 1, 4'd1, 0, 16'd1};
        vt[3] = '{0, 0, 64'h0, 1, 0, 0, 32'h0, 0, 4'd0, 0, 16'd1};
        vt[4] = '{0, 1, 64'h1122334455667788, 0, 0,
                  1, 32'h55667788, 0, 4'd1, 0, 16'd2};
        vt[5] = '{0, 0, 64'h0, 1, 0, 1, 32'h11223344, 1, 4'd1, 0, 16'd2};
        vt[6] = '{1, 1, 64'hffffffffffffffff, 0, 0,
                  0, 32'h0, 0, 4'd0, 0, 16'd0};
        vt[7] = '{0, 0, 64'h0, 0, 0, 0, 32'h0, 0, 4'd0, 0, 16'd0};

        for (int i = 0; i < 8; i++) begin
            step(vt[i].rst, vt[i].dv, vt[i].data, vt[i].rr, vt[i].clr);
            chk($sformatf("v%0d_rvalid", i), 64'(rvalid), 64'(vt[i].e_rv));
            chk($sformatf("v%0d_rdata", i), 64'(rdata), 64'(vt[i].e_rd));
            chk($sformatf("v%0d_hi", i), 64'(word_hi), 64'(vt[i].e_hi));
            chk($sformatf("v%0d_level", i), 64'(level), 64'(vt[i].e_lvl));
            chk($sformatf("v%0d_ovf", i), 64'(ovf), 64'(vt[i].e_ovf));
            chk($sformatf("v%0d_count", i), 64'(count), 64'(vt[i].e_cnt));
        end

        // Fill to full, then one more result is lost.
        for (int i = 0; i < 8; i++) begin
            step(0, 1, {32'(i), 32'(32'hA0 + i)}, 0, 0);
        end
        chk("full_level", 64'(level), 64'd8);
        chk("full_ovf", 64'(ovf), 64'd0);
        step(0, 1, 64'h9999999999999999, 0, 0);
        chk("drop_ovf", 64'(ovf), 64'd1);
        chk("drop_count", 64'(count), 64'd8);
        chk("drop_level", 64'(level), 64'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_lo%0d", i), 64'(rdata), 64'(32'hA0 + i));
            chk($sformatf("drain_hilo%0d", i), 64'(word_hi), 64'd0);
            step(0, 0, 0, 1, 0);
            chk($sformatf("drain_hi%0d", i), 64'(rdata), 64'(i));
            chk($sformatf("drain_hihi%0d", i), 64'(word_hi), 64'd1);
            step(0, 0, 0, 1, 0);
        end
        chk("drain_rvalid", 64'(rvalid), 64'd0);
        chk("drain_rdata", 64'(rdata), 64'd0);

        // Clear alone, then a drop alongside a clear keeps the flag.
        step(0, 0, 0, 0, 1);
        chk("clr_alone", 64'(ovf), 64'd0);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, {32'(32'h10000000 + i), 32'(32'h20000000 + i)}, 0, 0);
        end
        step(0, 1, 64'h7777777777777777, 0, 1);
        chk("clr_drop_ovf", 64'(ovf), 64'd1);
        chk("clr_drop_count", 64'(count), 64'd16);
        step(0, 0, 0, 0, 1);
        chk("clr_after", 64'(ovf), 64'd0);

        // Full FIFO: pop on the same edge as a write makes room.
        step(0, 0, 0, 1, 0);
        chk("f3_hi", 64'(word_hi), 64'd1);
        nv = 64'hcafef00ddeadbeef;
        step(0, 1, nv, 1, 0);
        chk("f3_ovf", 64'(ovf), 64'd0);
        chk("f3_level", 64'(level), 64'd8);
        chk("f3_count", 64'(count), 64'd17);
        chk("f3_hi0", 64'(word_hi), 64'd0);
        for (int i = 1; i < 8; i++) begin
            chk($sformatf("f3_lo%0d", i), 64'(rdata), 64'(32'h20000000 + i));
            step(0, 0, 0, 1, 0);
            chk($sformatf("f3_hi%0d", i), 64'(rdata), 64'(32'h10000000 + i));
            step(0, 0, 0, 1, 0);
        end
        chk("f3_new_lo", 64'(rdata), 64'hdeadbeef);
        step(0, 0, 0, 1, 0);
        chk("f3_new_hi", 64'(rdata), 64'hcafef00d);
        step(0, 0, 0, 1, 0);
        chk("f3_empty", 64'(rvalid), 64'd0);

        // Result every cycle against a full-rate reader.
        step(1, 0, 0, 0, 0);
        mreset();
        for (int i = 0; i < 16; i++) begin
            mstep(1, 64'h4000000000000000 + 64'(i), 1, 0);
        end
        chk("cont_count", 64'(count), 64'd15);
        chk("cont_ovf", 64'(ovf), 64'd1);
        chk("cont_level", 64'(level), 64'd8);
        for (int i = 0; i < 20; i++) begin
            mstep(0, 0, 1, 0);
        end
        chk("cont_empty", 64'(rvalid), 64'd0);

        // Reset while an entry is half read.
        step(0, 1, 64'h0123456789abcdef, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("hr_hi", 64'(word_hi), 64'd1);
        step(1, 0, 0, 0, 0);
        chk("hr_rvalid", 64'(rvalid), 64'd0);
        chk("hr_hi0", 64'(word_hi), 64'd0);
        chk("hr_level", 64'(level), 64'd0);
        chk("hr_count", 64'(count), 64'd0);
        chk("hr_ovf", 64'(ovf), 64'd0);

        // Random traffic checked against the queue model.
        mreset();
        ndv = 0;
        while (ndv < 1000) begin
            logic d;
            logic rr;
            d  = ($urandom_range(0, 99) < 40);
            rr = ($urandom_range(0, 99) < 85);
            if (d) ndv++;
            mstep(d, {$urandom, $urandom}, rr,
                  ($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 40; i++) begin
            mstep(0, 0, 1, 0);
        end
        chk("rand_empty", 64'(rvalid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
